// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester IDs, beat-counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      WDATA = 2'd2,
      RDATA = 2'd3
   } arbState_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } reqId_t;

   // Beat counter must still be one bit wide for single-beat bursts.
   function automatic int beatCntW(input int burst);
      return (burst > 1) ? $clog2(burst) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant between icache and dcache refill paths.
// Latency: grant is combinational from requests; last-grant history updates on the clock.
// Backpressure: none; grantValid only asserts while enable is high.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             arbitration window (arbiter idle)
//   reqIc, reqDc       request lines
//   grantValid         some requester wins this cycle
//   grantId            winning requester
//   update, updateId   record the requester that just finished a transaction
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   enable,
   input  logic   reqIc,
   input  logic   reqDc,
   output logic   grantValid,
   output reqId_t grantId,
   input  logic   update,
   input  reqId_t updateId
);

   reqId_t lastGrant;

   // Reset to icache so the dcache wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastGrant <= REQ_IC;
      end else if (update) begin
         lastGrant <= updateId;
      end
   end

   always_comb begin
      grantValid = enable && (reqIc || reqDc);
      grantId    = REQ_IC;
      if (reqIc && reqDc) begin
         grantId = (lastGrant == REQ_IC) ? REQ_DC : REQ_IC;
      end else if (reqDc) begin
         grantId = REQ_DC;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory command/data interface between icache refill and dcache refill/writeback.
// Latency: req_valid -> mem_cmd_valid 1 cycle; mem_rdf beat -> rdata/rdata_valid 1 cycle.
// Backpressure: mem_cmd_ready gates req_ready; mem_wdf_ready gates dc_wdata_ready; read data has none.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ic_req_*                          icache read-burst request (valid/addr/ready) and ic_rdata_valid
//   dc_req_*, dc_wdata, dc_wmask      dcache request, write beats, active-low byte mask
//   dc_wdata_ready, dc_rdata_valid    dcache write-beat accept and read-beat valid
//   rdata                             registered read beat shared by both caches
//   mem_cmd_*, mem_wdf_*, mem_rdf_*   memory controller command, write-data and read-data channels
//   busy                              a transaction is in progress
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 31,
   parameter int DATA_W = 128,
   parameter int MASK_W = 16,
   parameter int BURST  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   output logic              ic_rdata_valid,
   input  logic              dc_req_valid,
   input  logic              dc_req_rnw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   output logic              dc_req_ready,
   input  logic [DATA_W-1:0] dc_wdata,
   input  logic [MASK_W-1:0] dc_wmask,
   output logic              dc_wdata_ready,
   output logic              dc_rdata_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic              mem_cmd_rnw,
   output logic              mem_wdf_valid,
   input  logic              mem_wdf_ready,
   output logic [DATA_W-1:0] mem_wdf_data,
   output logic [MASK_W-1:0] mem_wdf_mask,
   output logic              mem_wdf_last,
   input  logic              mem_rdf_valid,
   input  logic [DATA_W-1:0] mem_rdf_data,
   output logic              busy
);

   localparam int               CNT_W     = beatCntW(BURST);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

   arbState_t         state;
   reqId_t            grantId;
   reqId_t            rdOwner;
   logic [ADDR_W-1:0] cmdAddr;
   logic              cmdRnw;
   logic [CNT_W-1:0]  beatCnt;
   logic              rdVld;
   logic [DATA_W-1:0] rdataQ;
   logic              staleOk;

   logic              arbValid;
   reqId_t            arbGrant;
   logic              wrBeat;
   logic              rdBeat;
   logic              lastBeat;
   logic              txnDone;

   assign lastBeat = (beatCnt == LAST_BEAT);
   assign wrBeat   = (state == WDATA) && mem_wdf_ready;
   assign rdBeat   = (state == RDATA) && mem_rdf_valid;
   assign txnDone  = (wrBeat || rdBeat) && lastBeat;

   rr_arbiter2 uArb (
      .clk        (clk),
      .rst        (rst),
      .enable     (state == IDLE),
      .reqIc      (ic_req_valid),
      .reqDc      (dc_req_valid),
      .grantValid (arbValid),
      .grantId    (arbGrant),
      .update     (txnDone),
      .updateId   (grantId)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grantId <= REQ_IC;
         rdOwner <= REQ_IC;
         cmdAddr <= '0;
         cmdRnw  <= 1'b0;
         beatCnt <= '0;
         rdVld   <= 1'b0;
         rdataQ  <= '0;
         // Beats of a read burst abandoned by reset may still arrive; remember that
         // so the stray-beat check below does not flag them.
         staleOk <= staleOk || (state == RDATA);
      end else begin
         rdVld <= 1'b0;
         case (state)
            IDLE: begin
               if (arbValid) begin
                  grantId <= arbGrant;
                  cmdAddr <= (arbGrant == REQ_DC) ? dc_req_addr : ic_req_addr;
                  cmdRnw  <= (arbGrant == REQ_DC) ? dc_req_rnw : 1'b1;
                  state   <= CMD;
               end
            end
            CMD: begin
               if (mem_cmd_ready) begin
                  state   <= cmdRnw ? RDATA : WDATA;
                  staleOk <= 1'b0;
               end
            end
            WDATA: begin
               if (mem_wdf_ready) begin
                  if (lastBeat) begin
                     beatCnt <= '0;
                     state   <= IDLE;
                  end else begin
                     beatCnt <= beatCnt + 1'b1;
                  end
               end
            end
            RDATA: begin
               if (mem_rdf_valid) begin
                  rdVld   <= 1'b1;
                  rdOwner <= grantId;
                  rdataQ  <= mem_rdf_data;
                  if (lastBeat) begin
                     beatCnt <= '0;
                     state   <= IDLE;
                  end else begin
                     beatCnt <= beatCnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory read data has no backpressure, so a beat outside RDATA is lost.
   always_ff @(posedge clk) begin
      if (!rst && mem_rdf_valid) begin
         assert (state == RDATA || staleOk);
      end
   end

   assign mem_cmd_valid  = (state == CMD);
   assign mem_cmd_addr   = cmdAddr;
   assign mem_cmd_rnw    = cmdRnw;
   assign ic_req_ready   = (state == CMD) && (grantId == REQ_IC) && mem_cmd_ready;
   assign dc_req_ready   = (state == CMD) && (grantId == REQ_DC) && mem_cmd_ready;

   assign mem_wdf_valid  = (state == WDATA);
   assign mem_wdf_data   = dc_wdata;
   assign mem_wdf_mask   = dc_wmask;
   assign mem_wdf_last   = (state == WDATA) && lastBeat;
   assign dc_wdata_ready = wrBeat;

   // rdOwner is captured with the beat so a new grant cannot steal the final beat.
   assign ic_rdata_valid = rdVld && (rdOwner == REQ_IC);
   assign dc_rdata_valid = rdVld && (rdOwner == REQ_DC);
   assign rdata          = rdataQ;
   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (pending requests, round-robin history, beat counts).
// Outputs are sampled 1ns after the falling edge.
module tb_mem_arbiter;

   localparam int AW    = 31;
   localparam int DW    = 128;
   localparam int MW    = 16;
   localparam int BURST = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ic_req_valid = 1'b0;
   logic [AW-1:0] ic_req_addr = '0;
   logic          ic_req_ready;
   logic          ic_rdata_valid;
   logic          dc_req_valid = 1'b0;
   logic          dc_req_rnw = 1'b0;
   logic [AW-1:0] dc_req_addr = '0;
   logic          dc_req_ready;
   logic [DW-1:0] dc_wdata = '0;
   logic [MW-1:0] dc_wmask = '0;
   logic          dc_wdata_ready;
   logic          dc_rdata_valid;
   logic [DW-1:0] rdata;
   logic          mem_cmd_valid;
   logic          mem_cmd_ready = 1'b0;
   logic [AW-1:0] mem_cmd_addr;
   logic          mem_cmd_rnw;
   logic          mem_wdf_valid;
   logic          mem_wdf_ready = 1'b0;
   logic [DW-1:0] mem_wdf_data;
   logic [MW-1:0] mem_wdf_mask;
   logic          mem_wdf_last;
   logic          mem_rdf_valid = 1'b0;
   logic [DW-1:0] mem_rdf_data = '0;
   logic          busy;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .BURST(BURST)) dut (
      .clk(clk), .rst(rst),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_rdata_valid(ic_rdata_valid),
      .dc_req_valid(dc_req_valid), .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
      .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
      .dc_wdata_ready(dc_wdata_ready), .dc_rdata_valid(dc_rdata_valid), .rdata(rdata),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
      .mem_cmd_rnw(mem_cmd_rnw), .mem_wdf_valid(mem_wdf_valid), .mem_wdf_ready(mem_wdf_ready),
      .mem_wdf_data(mem_wdf_data), .mem_wdf_mask(mem_wdf_mask), .mem_wdf_last(mem_wdf_last),
      .mem_rdf_valid(mem_rdf_valid), .mem_rdf_data(mem_rdf_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int nCompared = 0;
   int nMismatched = 0;

   // Requester-side stimulus state
   bit            icPend = 0;
   logic [AW-1:0] icAddr = '0;
   bit            dcPend = 0;
   bit            dcRnw = 0;
   logic [AW-1:0] dcAddr = '0;
   bit            maskFixed = 0;
   logic [MW-1:0] fixedMask = '0;

   // Memory stub knobs
   bit manualMem = 1;
   int cmdP = 100;
   int wdfP = 100;
   int rdfP = 100;

   // Reference model: one transaction in flight at most
   bit            modelOn = 0;
   bit            mBusy = 0;
   bit            mCmdPhase = 0;
   bit            mGrant = 0;     // 0 = icache, 1 = dcache
   bit            mLast = 0;
   logic [AW-1:0] mAddr = '0;
   bit            mRnw = 0;
   int            mBeats = 0;
   bit            expIcRv = 0;
   bit            expDcRv = 0;
   logic [DW-1:0] expRdata = '0;

   // Observations of DUT behaviour
   int  cyc = 0;
   int  grantLog[$];
   int  wrPulses = 0;
   int  lastAcc = 0;
   int  rvCount = 0;
   int  wrEndCyc = 0;
   int  cmdRiseCyc = 0;
   bit  prevCmdVld = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock cycle: drive, settle, check against model, advance model, wait next negedge.
   task automatic step();
      bit nIc, nDc, g, wv;
      if (!manualMem) begin
         mem_cmd_ready = ($urandom_range(99) < cmdP);
         mem_wdf_ready = ($urandom_range(99) < wdfP);
         mem_rdf_valid = mBusy && !mCmdPhase && mRnw && ($urandom_range(99) < rdfP);
         mem_rdf_data  = rand128();
      end
      ic_req_valid = icPend;
      ic_req_addr  = icAddr;
      dc_req_valid = dcPend;
      dc_req_addr  = dcAddr;
      dc_req_rnw   = dcRnw;
      dc_wdata     = rand128();
      dc_wmask     = maskFixed ? fixedMask : MW'($urandom);
      #1;
      if (modelOn) begin
         wv = mBusy && !mCmdPhase && !mRnw;
         chk("busy", busy, mBusy);
         chk("cmd_vld", mem_cmd_valid, mBusy && mCmdPhase);
         if (mBusy && mCmdPhase) begin
            chk("cmd_addr", mem_cmd_addr, mAddr);
            chk("cmd_rnw", mem_cmd_rnw, mRnw);
         end
         chk("ic_rdy", ic_req_ready, mBusy && mCmdPhase && !mGrant && mem_cmd_ready);
         chk("dc_rdy", dc_req_ready, mBusy && mCmdPhase && mGrant && mem_cmd_ready);
         chk("wdf_vld", mem_wdf_valid, wv);
         chk("wdat_rdy", dc_wdata_ready, wv && mem_wdf_ready);
         if (wv) begin
            chk("wdf_data", mem_wdf_data, dc_wdata);
            chk("wdf_mask", mem_wdf_mask, dc_wmask);
            chk("wdf_last", mem_wdf_last, mBeats == BURST - 1);
         end
         chk("ic_rv", ic_rdata_valid, expIcRv);
         chk("dc_rv", dc_rdata_valid, expDcRv);
         if (expIcRv || expDcRv) chk("rdata", rdata, expRdata);
      end
      // DUT observations
      if (ic_req_ready) grantLog.push_back(0);
      if (dc_req_ready) grantLog.push_back(1);
      if (dc_wdata_ready) wrPulses++;
      if (mem_wdf_valid && mem_wdf_ready && mem_wdf_last) begin
         lastAcc++;
         wrEndCyc = cyc;
      end
      if (mem_cmd_valid && !prevCmdVld) cmdRiseCyc = cyc;
      prevCmdVld = mem_cmd_valid;
      if (ic_rdata_valid || dc_rdata_valid) rvCount++;
      // Model advance for the coming rising edge
      if (rst) begin
         modelOn = 1; mBusy = 0; mCmdPhase = 0; mBeats = 0; mLast = 0;
         expIcRv = 0; expDcRv = 0; expRdata = '0;
      end else begin
         nIc = 0; nDc = 0;
         if (!mBusy) begin
            if (icPend || dcPend) begin
               g = (icPend && dcPend) ? !mLast : dcPend;
               mBusy = 1; mCmdPhase = 1; mGrant = g; mBeats = 0;
               mAddr = g ? dcAddr : icAddr;
               mRnw  = g ? dcRnw : 1'b1;
            end
         end else if (mCmdPhase) begin
            if (mem_cmd_ready) begin
               mCmdPhase = 0;
               if (mGrant) dcPend = 0; else icPend = 0;
            end
         end else if (!mRnw) begin
            if (mem_wdf_ready) begin
               mBeats++;
               if (mBeats == BURST) begin mBusy = 0; mLast = 1; end
            end
         end else if (mem_rdf_valid) begin
            if (mGrant) nDc = 1; else nIc = 1;
            expRdata = mem_rdf_data;
            mBeats++;
            if (mBeats == BURST) begin mBusy = 0; mLast = mGrant; end
         end
         expIcRv = nIc;
         expDcRv = nDc;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic resetDut();
      icPend = 0; dcPend = 0; manualMem = 1;
      mem_cmd_ready = 0; mem_wdf_ready = 0; mem_rdf_valid = 0;
      rst = 1;
      step();
      step();
      rst = 0;
      grantLog.delete();
      wrPulses = 0; lastAcc = 0; rvCount = 0;
   endtask

   task automatic runIdle(input int budget);
      int n = 0;
      while ((mBusy || icPend || dcPend) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", mBusy || icPend || dcPend, 0);
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] beatA, beatB;
      beatA = {32{4'hA}};
      beatB = {32{4'hB}};
      @(negedge clk);

      // Reset state, then a lone icache read burst
      resetDut();
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_cmd_vld", mem_cmd_valid, 0);
      chk("rst_rv", ic_rdata_valid || dc_rdata_valid, 0);
      icPend = 1; icAddr = 31'h0001000;
      step();
      chk("t1_cmd_vld", mem_cmd_valid, 1);
      chk("t1_cmd_rnw", mem_cmd_rnw, 1);
      chk("t1_cmd_addr", mem_cmd_addr, 31'h0001000);
      mem_cmd_ready = 1;
      step();
      chk("t1_grants", grantLog.size(), 1);
      mem_cmd_ready = 0; mem_rdf_valid = 1; mem_rdf_data = beatA;
      step();
      chk("t1_beat0_rv", ic_rdata_valid, 1);
      chk("t1_beat0", rdata, beatA);
      mem_rdf_data = beatB;
      step();
      chk("t1_beat1_rv", ic_rdata_valid, 1);
      chk("t1_beat1", rdata, beatB);
      chk("t1_busy_end", busy, 0);
      mem_rdf_valid = 0;
      step();
      chk("t1_rv_end", ic_rdata_valid, 0);

      // Tie after reset goes to dcache; a repeated tie alternates to icache
      resetDut();
      manualMem = 0; cmdP = 100; wdfP = 100; rdfP = 100;
      icPend = 1; icAddr = 31'h0000100;
      dcPend = 1; dcRnw = 1; dcAddr = 31'h0000200;
      for (int i = 0; i < 20 && grantLog.size() == 0; i++) step();
      dcPend = 1; dcRnw = 1; dcAddr = 31'h0000300;
      runIdle(200);
      chk("t2_ngrants", grantLog.size(), 3);
      if (grantLog.size() >= 3) begin
         chk("t2_first_dc", grantLog[0], 1);
         chk("t2_tie_ic", grantLog[1], 0);
         chk("t2_third_dc", grantLog[2], 1);
      end

      // dcache write with a 3-cycle stall on beat 0
      resetDut();
      maskFixed = 1; fixedMask = '0;
      dcPend = 1; dcRnw = 0; dcAddr = 31'h0002000;
      mem_cmd_ready = 1;
      step();
      chk("t3_cmd_rnw", mem_cmd_rnw, 0);
      chk("t3_cmd_addr", mem_cmd_addr, 31'h0002000);
      step();
      mem_cmd_ready = 0; mem_wdf_ready = 0;
      repeat (3) begin
         step();
         chk("t3_stall_vld", mem_wdf_valid, 1);
         chk("t3_stall_rdy", dc_wdata_ready, 0);
         chk("t3_stall_last", mem_wdf_last, 0);
      end
      mem_wdf_ready = 1;
      step();
      chk("t3_beat1_last", mem_wdf_last, 1);
      step();
      chk("t3_busy_end", busy, 0);
      chk("t3_wr_pulses", wrPulses, 2);
      chk("t3_last_acc", lastAcc, 1);
      mem_wdf_ready = 0; maskFixed = 0;

      // icache request arriving during a dcache write waits for it to finish
      resetDut();
      dcPend = 1; dcRnw = 0; dcAddr = 31'h0002040;
      mem_cmd_ready = 1;
      step();
      step();
      icPend = 1; icAddr = 31'h0003000;
      mem_wdf_ready = 0;
      repeat (4) begin
         step();
         chk("t4_ic_wait", ic_req_ready, 0);
      end
      mem_wdf_ready = 1;
      step();
      step();
      mem_wdf_ready = 0;
      step();
      step();
      chk("t4_cmd_gap", cmdRiseCyc - wrEndCyc, 2);
      chk("t4_order_n", grantLog.size(), 2);
      if (grantLog.size() >= 2) begin
         chk("t4_order_dc", grantLog[0], 1);
         chk("t4_order_ic", grantLog[1], 0);
      end
      manualMem = 0;
      runIdle(200);

      // Reset in the middle of a read burst; the late beat must be dropped
      resetDut();
      icPend = 1; icAddr = 31'h0005000;
      mem_cmd_ready = 1;
      step();
      step();
      mem_cmd_ready = 0; mem_rdf_valid = 1; mem_rdf_data = beatA;
      step();
      mem_rdf_valid = 0; rst = 1;
      step();
      rst = 0;
      chk("t5_busy", busy, 0);
      chk("t5_rdata", rdata, 0);
      chk("t5_ic_rv", ic_rdata_valid, 0);
      chk("t5_dc_rv", dc_rdata_valid, 0);
      chk("t5_cmd_vld", mem_cmd_valid, 0);
      chk("t5_wdf_vld", mem_wdf_valid, 0);
      rvCount = 0;
      mem_rdf_valid = 1; mem_rdf_data = beatB;
      step();
      mem_rdf_valid = 0;
      step();
      chk("t5_late_rv", rvCount, 0);

      // Command held off by memory for 10 cycles stays stable with no ready pulse
      resetDut();
      dcPend = 1; dcRnw = 1; dcAddr = 31'h0004567;
      step();
      repeat (10) begin
         step();
         chk("t6_vld", mem_cmd_valid, 1);
         chk("t6_addr", mem_cmd_addr, 31'h0004567);
         chk("t6_rnw", mem_cmd_rnw, 1);
      end
      chk("t6_no_ready", grantLog.size(), 0);
      manualMem = 0;
      runIdle(200);

      // Randomized traffic
      resetDut();
      manualMem = 0; cmdP = 60; wdfP = 60; rdfP = 60;
      for (int i = 0; i < 4000; i++) begin
         if (!icPend && $urandom_range(99) < 30) begin
            icPend = 1; icAddr = AW'($urandom);
         end
         if (!dcPend && $urandom_range(99) < 30) begin
            dcPend = 1; dcAddr = AW'($urandom); dcRnw = $urandom_range(1);
         end
         step();
      end
      runIdle(500);
      chk("rand_progress", grantLog.size() > 100, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
